tcm_arbiter: RTL

- Shares one single-port sim_ram (ITCM/DTCM) between two requesters, port 0 (IFU) and port 1 (LSU), using valid/ready command and response channels.
- Round-robin arbitration; at most one outstanding transaction; one transaction per cycle when responses are accepted immediately.
- Holds the RAM read address stable while a read response stalls, so the RAM output register supplies the data with no extra buffer.
- Sits between the core pipeline and the TCM RAM instance.

---
 rtl/tcm_arbiter_if.sv | 28 ++
 rtl/tcm_arbiter.sv | 112 +++++++++++
 2 files changed

// File: rtl/tcm_arbiter_if.sv
// Requester-side command/response channel of the TCM arbiter.
// One instance per requester; the arbiter uses the slave modport.
interface tcm_arbiter_if #(
  parameter int DW = 32,
  parameter int MW = 4,
  parameter int AW = 32
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          cmd_read;
  logic [DW-1:0] cmd_wdata;
  logic [MW-1:0] cmd_wmask;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/tcm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port TCM RAM.
// One outstanding transaction; a stalled read keeps re-reading the same
// RAM word so the RAM output register holds the response data.
module tcm_arbiter #(
  parameter int DW  = 32,
  parameter int MW  = 4,
  parameter int AW  = 32,
  parameter int RAW = 9
) (
  input  logic           clk,
  input  logic           rst,
  tcm_arbiter_if.slave   p0,
  tcm_arbiter_if.slave   p1,
  output logic [RAW-1:0] ram_addr,
  output logic [DW-1:0]  ram_din,
  output logic           ram_we,
  output logic [MW-1:0]  ram_wem,
  input  logic [DW-1:0]  ram_dout
);

  logic           rsp_pend;
  logic           rsp_owner;
  logic           rsp_read;
  logic           rsp_err_r;
  logic           last_grant;
  logic [RAW-1:0] hold_addr;

  logic           gnt_valid;
  logic           gnt_sel;
  logic           owner_rsp_ready;
  logic           can_accept;
  logic           accept;
  logic [AW-1:0]  sel_addr;
  logic           sel_read;
  logic [DW-1:0]  sel_wdata;
  logic [MW-1:0]  sel_wmask;
  logic [RAW-1:0] sel_idx;
  logic           sel_err;
  logic [1:0]     unused_addr_lo;
  logic [DW-1:0]  rsp_data;

  // Grant selection, acceptance and command mux.
  always_comb begin
    gnt_valid = p0.cmd_valid | p1.cmd_valid;
    if (p0.cmd_valid & p1.cmd_valid) gnt_sel = ~last_grant;
    else                             gnt_sel = p1.cmd_valid;
    owner_rsp_ready = rsp_owner ? p1.rsp_ready : p0.rsp_ready;
    can_accept      = ~rsp_pend | owner_rsp_ready;
    accept          = ~rst & gnt_valid & can_accept;
    sel_addr        = gnt_sel ? p1.cmd_addr  : p0.cmd_addr;
    sel_read        = gnt_sel ? p1.cmd_read  : p0.cmd_read;
    sel_wdata       = gnt_sel ? p1.cmd_wdata : p0.cmd_wdata;
    sel_wmask       = gnt_sel ? p1.cmd_wmask : p0.cmd_wmask;
  end

  assign sel_idx        = sel_addr[RAW+1:2];
  assign sel_err        = |sel_addr[AW-1:RAW+2];
  assign unused_addr_lo = sel_addr[1:0];

  // Arbitration and outstanding-response state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend   <= 1'b0;
      rsp_owner  <= 1'b0;
      rsp_read   <= 1'b0;
      rsp_err_r  <= 1'b0;
      last_grant <= 1'b1;
      hold_addr  <= '0;
    end else begin
      if (accept) begin
        rsp_pend   <= 1'b1;
        rsp_owner  <= gnt_sel;
        last_grant <= gnt_sel;
        rsp_read   <= sel_read;
        rsp_err_r  <= sel_err;
        if (sel_read) hold_addr <= sel_idx;
      end else if (rsp_pend & owner_rsp_ready) begin
        rsp_pend <= 1'b0;
      end
    end
  end

  // RAM port: new command on accept, otherwise re-read the held word.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_we   = 1'b0;
    ram_wem  = '0;
    if (accept) begin
      ram_addr = sel_idx;
      ram_din  = sel_wdata;
      ram_we   = ~sel_read & ~sel_err;
      ram_wem  = sel_wmask;
    end else if (!rst) begin
      ram_addr = hold_addr;
    end
  end

  // Requester-side ready and response outputs; non-owner port stays zero.
  always_comb begin
    rsp_data     = (rsp_read & ~rsp_err_r) ? ram_dout : '0;
    p0.cmd_ready = accept & ~gnt_sel;
    p1.cmd_ready = accept &  gnt_sel;
    p0.rsp_valid = ~rst & rsp_pend & ~rsp_owner;
    p1.rsp_valid = ~rst & rsp_pend &  rsp_owner;
    p0.rsp_rdata = p0.rsp_valid ? rsp_data : '0;
    p1.rsp_rdata = p1.rsp_valid ? rsp_data : '0;
    p0.rsp_err   = p0.rsp_valid & rsp_err_r;
    p1.rsp_err   = p1.rsp_valid & rsp_err_r;
  end

endmodule
